// File: rtl/mem_port_ctrl.sv
// Per-processor load/store request controller in front of the shared memory arbiters.
// Optional grant-wait timeout is compiled in with `define MEM_PORT_TIMEOUT_EN.
module mem_port_ctrl #(
  parameter int BUS_SIZE = 128,
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_we,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [BUS_SIZE-1:0] i_cmd_wdata,
  input  logic [1:0]          i_cmd_size,
  output logic                o_rsp_valid,
  output logic [BUS_SIZE-1:0] o_rsp_data,
  output logic                o_rsp_err,
  output logic                o_req_rd,
  output logic                o_req_wr,
  input  logic                i_grant_rd,
  input  logic                i_grant_wr,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [BUS_SIZE-1:0] o_wr_data,
  output logic [1:0]          o_wr_size,
  input  logic [BUS_SIZE-1:0] i_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDWAIT, S_RSP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BUS_SIZE-1:0] wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic [BUS_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic                grant_hit;
  logic                timeout_hit;

  // Only a grant on the lane matching the latched command counts.
  assign grant_hit = (state_q == S_REQ) && (we_q ? i_grant_wr : i_grant_rd);

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_IDLE) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_REQ) && !grant_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // A grant in the final wait cycle takes priority over the timeout.
  assign timeout_hit = (state_q == S_REQ) && !grant_hit &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
  assign err_d       = timeout_hit;
  assign o_rsp_err   = err_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_rsp_err   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    rsp_data_d = rsp_data_q;
    lat_cnt_d  = lat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          size_d  = i_cmd_size;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (grant_hit) begin
          if (we_q) begin
            state_d = S_RSP;
          end else if (RD_LAT > 0) begin
            lat_cnt_d = 2'(RD_LAT - 1);
            state_d   = S_RDWAIT;
          end else begin
            rsp_data_d = i_rd_data;
            state_d    = S_RSP;
          end
        end else if (timeout_hit) begin
          state_d = S_RSP;
        end
      end
      S_RDWAIT: begin
        if (lat_cnt_q == 2'd0) begin
          rsp_data_d = i_rd_data;
          state_d    = S_RSP;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The command latch is reset so the memory lane shows zeros out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      rsp_data_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      rsp_data_q <= rsp_data_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_req_rd    = 1'b0;
    o_req_wr    = 1'b0;
    o_rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  o_cmd_ready = 1'b1;
      S_REQ: begin
        o_req_rd = !we_q;
        o_req_wr = we_q;
      end
      S_RSP:   o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign o_addr     = addr_q;
  assign o_wr_data  = wdata_q;
  assign o_wr_size  = size_q;
  assign o_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench: three controllers (RD_LAT 1, 0, 3) share one command/grant stream;
// expected responses are queued at grant time and matched when o_rsp_valid pulses.
module tb_mem_port_ctrl;

  localparam int NI         = 3;
  localparam int TB_TIMEOUT = 4;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [127:0] pat(input int c);
    logic [31:0] u;
    u = 32'(c);
    return {u ^ 32'hA5A5_0000, ~u, u + 32'h0000_1234, 32'h0000_1234 + (u << 16)};
  endfunction

  typedef struct {
    int           cyc;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_we, grant_rd, grant_wr;
  logic [15:0]  cmd_addr;
  logic [127:0] cmd_wdata;
  logic [1:0]   cmd_size;
  logic [127:0] rd_data;
  int           cyc = 0;

  logic         cmd_ready [NI];
  logic         rsp_valid [NI];
  logic         rsp_err   [NI];
  logic         req_rd    [NI];
  logic         req_wr    [NI];
  logic [127:0] rsp_data  [NI];
  logic [15:0]  addr      [NI];
  logic [127:0] wr_data   [NI];
  logic [1:0]   wr_size   [NI];

  exp_t         sb [NI][$];
  logic [127:0] last_load [NI];
  logic [15:0]  exp_addr;
  logic [127:0] exp_wdata;
  logic [1:0]   exp_size;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rd_data = pat(cyc);

  for (genvar k = 0; k < NI; k++) begin : g_dut
    mem_port_ctrl #(
      .BUS_SIZE(128), .ADDR_W(16), .RD_LAT(lat_of(k)), .TIMEOUT(TB_TIMEOUT)
    ) u_dut (
      .i_clk      (clk),
      .i_rstn     (rst_n),
      .i_cmd_valid(cmd_valid),
      .o_cmd_ready(cmd_ready[k]),
      .i_cmd_we   (cmd_we),
      .i_cmd_addr (cmd_addr),
      .i_cmd_wdata(cmd_wdata),
      .i_cmd_size (cmd_size),
      .o_rsp_valid(rsp_valid[k]),
      .o_rsp_data (rsp_data[k]),
      .o_rsp_err  (rsp_err[k]),
      .o_req_rd   (req_rd[k]),
      .o_req_wr   (req_wr[k]),
      .i_grant_rd (grant_rd),
      .i_grant_wr (grant_wr),
      .o_addr     (addr[k]),
      .o_wr_data  (wr_data[k]),
      .o_wr_size  (wr_size[k]),
      .i_rd_data  (rd_data)
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation of its instance.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_n && rsp_valid[k]) begin
        if (sb[k].size() == 0) begin
          check($sformatf("unexpected_rsp[%0d]", k), rsp_valid[k], 1'b0);
        end else begin
          exp_t e;
          e = sb[k].pop_front();
          check($sformatf("rsp_cycle[%0d]", k), 128'(cyc), 128'(e.cyc));
          check($sformatf("rsp_data[%0d]", k), rsp_data[k], e.data);
          check($sformatf("rsp_err[%0d]", k), rsp_err[k], e.err);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_ready[%0d]", tag, k), cmd_ready[k], 1'b1);
      check($sformatf("%s_req[%0d]", tag, k), {req_rd[k], req_wr[k]}, 2'b00);
      check($sformatf("%s_rsp[%0d]", tag, k), {rsp_valid[k], rsp_err[k]}, 2'b00);
      check($sformatf("%s_rdata[%0d]", tag, k), rsp_data[k], 128'd0);
      check($sformatf("%s_addr[%0d]", tag, k), addr[k], 16'd0);
      check($sformatf("%s_wdata[%0d]", tag, k), wr_data[k], 128'd0);
      check($sformatf("%s_wsize[%0d]", tag, k), wr_size[k], 2'd0);
    end
  endtask

  task automatic check_req(input logic we, input logic on);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("req_rd[%0d]", k), req_rd[k], on & ~we);
      check($sformatf("req_wr[%0d]", k), req_wr[k], on & we);
      check($sformatf("lane[%0d]", k), {addr[k], wr_data[k][15:0], wr_size[k]},
            {exp_addr, exp_wdata[15:0], exp_size});
      check($sformatf("lane_wdata[%0d]", k), wr_data[k], exp_wdata);
    end
  endtask

  task automatic push_exp(input logic we, input int g, input int rsp_tmo);
    for (int k = 0; k < NI; k++) begin
      exp_t e;
      e.err = 1'b0;
      if (rsp_tmo > 0) begin
        e.cyc = rsp_tmo;
        e.err = 1'b1;
      end else if (we) begin
        e.cyc = g + 1;
      end else begin
        e.cyc        = g + lat_of(k) + 1;
        last_load[k] = pat(g + lat_of(k));
      end
      e.data = last_load[k];
      sb[k].push_back(e);
    end
  endtask

  // One command: accept, gdelay grant-less REQ cycles, then a grant (or run into the timeout).
  task automatic run_cmd(input logic we, input logic [15:0] a, input logic [127:0] wd,
                         input logic [1:0] sz, input int gdelay, input bit grant_en,
                         input bit noise);
    int  req_start, nreq, g;
    bit  done;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd; cmd_size = sz;
    exp_addr = a; exp_wdata = wd; exp_size = sz;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    req_start = cyc;
    nreq = grant_en ? gdelay : TB_TIMEOUT;
    for (int i = 0; i < nreq; i++) begin
      if (noise) begin
        cmd_valid = 1'b1; cmd_we = ~we; cmd_addr = ~a; cmd_wdata = ~wd; cmd_size = ~sz;
        if (we) grant_rd = 1'b1;
        else    grant_wr = 1'b1;
      end
      @(negedge clk);
      check_req(we, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; grant_rd = 1'b0; grant_wr = 1'b0;
    end
    if (grant_en) begin
      if (we) grant_wr = 1'b1;
      else    grant_rd = 1'b1;
      g = cyc;
      push_exp(we, g, 0);
      @(negedge clk);
      check_req(we, 1'b1);
      @(posedge clk); #1;
      grant_rd = 1'b0; grant_wr = 1'b0;
    end else begin
      push_exp(we, 0, req_start + TB_TIMEOUT);
    end
    @(negedge clk);
    check_req(we, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        check($sformatf("addr_hold[%0d]", k), addr[k], exp_addr);
        if (!cmd_ready[k] || sb[k].size() != 0) done = 1'b0;
      end
    end
    check("drain", done, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_size = '0; grant_rd = 1'b0; grant_wr = 1'b0;
    for (int k = 0; k < NI; k++) last_load[k] = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Grants while idle must not start anything.
    @(posedge clk); #1;
    grant_rd = 1'b1; grant_wr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    grant_rd = 1'b0; grant_wr = 1'b0;
    @(negedge clk);
    check_idle("idle_grant");

    run_cmd(1'b1, 16'h0010, {16{8'hA5}}, 2'd2, 3, 1'b1, 1'b0);
    run_cmd(1'b0, 16'h0020, 128'h0, 2'd0, 0, 1'b1, 1'b0);
    run_cmd(1'b0, 16'h0031, 128'h0, 2'd1, 2, 1'b1, 1'b1);
    run_cmd(1'b1, 16'hBEEF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2'd1, 1, 1'b1, 1'b1);
    run_cmd(1'b0, 16'hFFFF, 128'h0, 2'd3, 0, 1'b1, 1'b0);
`ifdef MEM_PORT_TIMEOUT_EN
    run_cmd(1'b1, 16'h0400, {4{32'hDEAD_BEEF}}, 2'd2, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 16'h0401, 128'h0, 2'd0, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 16'h0402, 128'h0, 2'd0, TB_TIMEOUT - 1, 1'b1, 1'b0);
    run_cmd(1'b1, 16'h0403, 128'h5, 2'd1, TB_TIMEOUT - 1, 1'b1, 1'b0);
`endif

    // Asynchronous reset while requesting: requests drop at once, no response follows.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0777;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("pre_rst_req_rd[%0d]", k), req_rd[k], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_req[%0d]", k), {req_rd[k], req_wr[k]}, 2'b00);
      check($sformatf("rst_rsp[%0d]", k), rsp_valid[k], 1'b0);
      last_load[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("post_rst");

    run_cmd(1'b0, 16'h0020, 128'h0, 2'd0, 1, 1'b1, 1'b0);

    for (int k = 0; k < NI; k++) check($sformatf("sb_empty[%0d]", k), 32'(sb[k].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
